// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus master: operand sizes,
// memory write strobes and FSM state codes.
package lsu_pkg;

  // op_size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // mem_write encodings
  localparam logic [1:0] MW_IDLE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_BYTE = 2'b11;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ACC  = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

endpackage

// File: rtl/lsu_load_align.sv
// Load result formatting: the memory already returns the bytes starting
// at the requested address, so only extraction and extension remain.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] w,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  output logic [31:0] rdata
);

  // Pick the low byte/half of the returned word and extend it.
  always_comb begin
    rdata = w;
    case (op_size)
      SZ_BYTE: rdata = {{24{op_signed & w[7]}}, w[7:0]};
      SZ_HALF: rdata = {{16{op_signed & w[15]}}, w[15:0]};
      default: rdata = w;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus master: one request at a time, each memory access held
// for ACCESS_CYCLES clocks, halfword stores split into two byte writes.
//
// Handshake: a request is taken on a rising clk edge where req && ready;
// ready is high only in IDLE outside reset, and req is ignored otherwise.
// Completion is a single-cycle rsp_valid pulse; rsp_err and rsp_rdata are
// meaningful with it, and rsp_rdata holds until the next pulse.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic        op_we,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [11:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  inout  wire  [31:0] mem_bus,
  output logic        mem_read,
  output logic [1:0]  mem_write,
  output logic [11:0] mem_addr,
  output logic [1:0]  dbg_state
);

  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic          hi_q;      // second byte of a halfword store in flight
  logic [7:0]    hi_byte_q; // op_wdata[15:8] kept for the second half
  logic [31:0]   bus_q;     // data driven onto the bus during a store ACC
  logic [31:0]   load_word;
  logic          drive_en;

  assign ready     = (state == ST_IDLE) && !rst;
  assign dbg_state = state;

  // Bus is driven straight from registered state so reset releases it at once.
  assign drive_en = (state == ST_ACC) && we_q;
  assign mem_bus  = drive_en ? bus_q : 32'hzzzz_zzzz;

  lsu_load_align u_align (
    .w         (mem_bus),
    .op_size   (size_q),
    .op_signed (sgn_q),
    .rdata     (load_word)
  );

  // Request FSM, access counter and all registered bus/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      sgn_q     <= 1'b0;
      hi_q      <= 1'b0;
      hi_byte_q <= 8'h00;
      bus_q     <= 32'h0;
      mem_read  <= 1'b0;
      mem_write <= MW_IDLE;
      mem_addr  <= 12'h000;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q      <= op_we;
            size_q    <= op_size;
            sgn_q     <= op_signed;
            hi_byte_q <= op_wdata[15:8];
            hi_q      <= 1'b0;
            if (op_size == SZ_ILL) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state    <= ST_ACC;
              cnt      <= '0;
              mem_addr <= op_addr;
              if (op_we) begin
                mem_write <= (op_size == SZ_WORD) ? MW_WORD : MW_BYTE;
                bus_q     <= (op_size == SZ_WORD) ? op_wdata : {24'h0, op_wdata[7:0]};
              end else begin
                mem_read <= 1'b1;
              end
            end
          end
        end
        ST_ACC: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= MW_IDLE;
            if (we_q && (size_q == SZ_HALF) && !hi_q) begin
              state <= ST_GAP;
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= we_q ? 32'h0 : load_word;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          state     <= ST_ACC;
          hi_q      <= 1'b1;
          mem_addr  <= mem_addr + 12'd1;
          mem_write <= MW_BYTE;
          bus_q     <= {24'h0, hi_byte_q};
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master with ACCESS_CYCLES = 4. Cycle numbers
// in tags count the accept edge as cycle 0; all sampling is on negedges.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic        ready;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [11:0] op_addr;
  logic [31:0] op_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  wire  [31:0] mem_bus;
  logic        mem_read;
  logic [1:0]  mem_write;
  logic [11:0] mem_addr;
  logic [1:0]  dbg_state;
  logic [31:0] rd_word;

  int n_cmp;
  int n_err;
  logic [32:0] exp_q[$]; // {rsp_err, rsp_rdata} per expected response

  lsu_bus_master #(.ACCESS_CYCLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ready     (ready),
    .op_we     (op_we),
    .op_size   (op_size),
    .op_signed (op_signed),
    .op_addr   (op_addr),
    .op_wdata  (op_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_bus   (mem_bus),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .dbg_state (dbg_state)
  );

  // Memory model: returns rd_word while mem_read is high.
  assign mem_bus = mem_read ? rd_word : 32'hzzzz_zzzz;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_quiet();
    return (mem_bus === 32'hzzzz_zzzz) || (mem_bus === 32'h0);
  endfunction

  // Scoreboard: every rsp_valid pops one expected response.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 1'b1, 1'b0);
      else check("rsp", {rsp_err, rsp_rdata}, exp_q.pop_front());
    end
  end

  // Driver: called at a negedge with the DUT idle; returns at the cycle-1 negedge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [11:0] addr, input logic [31:0] wdata);
    check("ready_before_accept", ready, 1'b1);
    req = 1'b1; op_we = we; op_size = size; op_signed = sgn;
    op_addr = addr; op_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Single-access op: ACC in 1..N, RESP N+1, ready at N+2.
  task automatic do_single(input string nm, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input logic [1:0] exp_mw,
                           input logic [31:0] exp_bus, input logic [31:0] exp_rdata);
    rd_word = rword;
    exp_q.push_back({1'b0, exp_rdata});
    issue(we, size, sgn, addr, wdata);
    for (int c = 1; c <= N + 2; c++) begin
      if (c <= N) begin
        check($sformatf("%s_rd_c%0d", nm, c), mem_read, !we);
        check($sformatf("%s_mw_c%0d", nm, c), mem_write, exp_mw);
        check($sformatf("%s_addr_c%0d", nm, c), mem_addr, addr);
        check($sformatf("%s_rv_c%0d", nm, c), rsp_valid, 1'b0);
        if (we) check($sformatf("%s_bus_c%0d", nm, c), mem_bus, exp_bus);
      end else if (c == N + 1) begin
        check($sformatf("%s_rv_c%0d", nm, c), rsp_valid, 1'b1);
        check($sformatf("%s_rd_c%0d", nm, c), mem_read, 1'b0);
        check($sformatf("%s_mw_c%0d", nm, c), mem_write, MW_IDLE);
        check($sformatf("%s_rdy_c%0d", nm, c), ready, 1'b0);
      end else begin
        check($sformatf("%s_rdy_c%0d", nm, c), ready, 1'b1);
        check($sformatf("%s_rv_c%0d", nm, c), rsp_valid, 1'b0);
        check($sformatf("%s_hold_c%0d", nm, c), rsp_rdata, exp_rdata);
        check($sformatf("%s_quiet_c%0d", nm, c), bus_quiet(), 1'b1);
      end
      if (c < N + 2) @(negedge clk);
    end
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // Stimulus
  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; req = 1'b0; op_we = 1'b0; op_size = SZ_BYTE; op_signed = 1'b0;
    op_addr = 12'h0; op_wdata = 32'h0; rd_word = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_rd", mem_read, 1'b0);
    check("rst_mw", mem_write, MW_IDLE);
    check("rst_addr", mem_addr, 12'h000);
    check("rst_rv", rsp_valid, 1'b0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_quiet", bus_quiet(), 1'b1);
    rst = 1'b0;
    #1 check("rst_release_ready", ready, 1'b1);
    @(negedge clk);

    // Loads
    do_single("ldw", 1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, MW_IDLE, 32'h0, 32'hDEADBEEF);
    do_single("ldbs", 1'b0, SZ_BYTE, 1'b1, 12'h123, 32'h0, 32'h00000080, MW_IDLE, 32'h0, 32'hFFFFFF80);
    do_single("ldhu", 1'b0, SZ_HALF, 1'b0, 12'h3FE, 32'h0, 32'h1234F00D, MW_IDLE, 32'h0, 32'h0000F00D);
    do_single("ldhs", 1'b0, SZ_HALF, 1'b1, 12'h801, 32'h0, 32'h77778001, MW_IDLE, 32'h0, 32'hFFFF8001);
    do_single("ldbu", 1'b0, SZ_BYTE, 1'b0, 12'h555, 32'h0, 32'hFFFFFF9C, MW_IDLE, 32'h0, 32'h0000009C);

    // Stores
    do_single("stw", 1'b1, SZ_WORD, 1'b0, 12'h044, 32'h12345678, 32'h0, MW_WORD, 32'h12345678, 32'h0);
    do_single("stb", 1'b1, SZ_BYTE, 1'b0, 12'h007, 32'hA5A5A5C3, 32'h0, MW_BYTE, 32'h000000C3, 32'h0);

    // Halfword store across the address wrap
    exp_q.push_back(33'h0);
    issue(1'b1, SZ_HALF, 1'b0, 12'hFFF, 32'h0000ABCD);
    for (int c = 1; c <= 2 * N + 3; c++) begin
      if (c <= N) begin
        check($sformatf("sth_mw_c%0d", c), mem_write, MW_BYTE);
        check($sformatf("sth_addr_c%0d", c), mem_addr, 12'hFFF);
        check($sformatf("sth_bus_c%0d", c), mem_bus, 32'h000000CD);
        check($sformatf("sth_rd_c%0d", c), mem_read, 1'b0);
      end else if (c == N + 1) begin
        check("sth_gap_mw", mem_write, MW_IDLE);
        check("sth_gap_quiet", bus_quiet(), 1'b1);
        check("sth_gap_addr", mem_addr, 12'hFFF);
        check("sth_gap_rv", rsp_valid, 1'b0);
      end else if (c <= 2 * N + 1) begin
        check($sformatf("sth_mw_c%0d", c), mem_write, MW_BYTE);
        check($sformatf("sth_addr_c%0d", c), mem_addr, 12'h000);
        check($sformatf("sth_bus_c%0d", c), mem_bus, 32'h000000AB);
        check($sformatf("sth_rv_c%0d", c), rsp_valid, 1'b0);
      end else if (c == 2 * N + 2) begin
        check("sth_rv_c10", rsp_valid, 1'b1);
        check("sth_mw_c10", mem_write, MW_IDLE);
      end else begin
        check("sth_rdy_c11", ready, 1'b1);
      end
      if (c < 2 * N + 3) @(negedge clk);
    end

    // Illegal size: immediate error response, no bus activity
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b1, SZ_ILL, 1'b0, 12'h0F0, 32'hFFFFFFFF);
    check("ill_rv_c1", rsp_valid, 1'b1);
    check("ill_mw_c1", mem_write, MW_IDLE);
    check("ill_rd_c1", mem_read, 1'b0);
    check("ill_quiet_c1", bus_quiet(), 1'b1);
    @(negedge clk);
    check("ill_rdy_c2", ready, 1'b1);
    check("ill_mw_c2", mem_write, MW_IDLE);

    // req held high through two word stores
    exp_q.push_back(33'h0);
    exp_q.push_back(33'h0);
    issue(1'b1, SZ_WORD, 1'b0, 12'h100, 32'h11112222);
    req = 1'b1; op_addr = 12'h200; op_wdata = 32'h33334444;
    for (int c = 1; c <= 2 * N + 4; c++) begin
      if (c <= N) begin
        check($sformatf("b2b_a_addr_c%0d", c), mem_addr, 12'h100);
        check($sformatf("b2b_a_bus_c%0d", c), mem_bus, 32'h11112222);
      end
      if (c == N + 1) check("b2b_rdy_c5", ready, 1'b0);
      if (c == N + 2) check("b2b_rdy_c6", ready, 1'b1);
      if (c > N + 2 && c <= 2 * N + 2) begin
        check($sformatf("b2b_b_addr_c%0d", c), mem_addr, 12'h200);
        check($sformatf("b2b_b_mw_c%0d", c), mem_write, MW_WORD);
        check($sformatf("b2b_b_bus_c%0d", c), mem_bus, 32'h33334444);
        req = 1'b0;
      end
      if (c == 2 * N + 3) check("b2b_b_rv_c11", rsp_valid, 1'b1);
      if (c == 2 * N + 4) check("b2b_rdy_c12", ready, 1'b1);
      if (c < 2 * N + 4) @(negedge clk);
    end

    // Reset in cycle 2 of a word store: dropped, no response
    issue(1'b1, SZ_WORD, 1'b0, 12'h0AA, 32'h5555AAAA);
    check("rs_mw_c1", mem_write, MW_WORD);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rs_mw", mem_write, MW_IDLE);
    check("rs_quiet", bus_quiet(), 1'b1);
    check("rs_addr", mem_addr, 12'h000);
    check("rs_ready", ready, 1'b0);
    check("rs_rv", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rs_ready_after", ready, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("rs_norsp_%0d", c), rsp_valid, 1'b0);
      check($sformatf("rs_idle_mw_%0d", c), mem_write, MW_IDLE);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store bus master placed between the CPU load/store path and the 32-bit shared tri-state memory bus. Accepts one request at a time through a ready/req handshake and drives the memory control lines (`mem_read`, `mem_write`, `mem_addr`) and the bus. Holds every access stable for the memory's fixed access window. Returns load data with byte/halfword extraction and sign/zero extension. Splits halfword stores into two byte writes, since the memory supports only word and byte writes.

## Interface
- `ACCESS_CYCLES`, default 4: clk cycles each memory access is held; minimum 2.
- `clk`  in  1  memory/system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  1  request valid; accepted when `req && ready`.
- `ready`  out  1  high only in IDLE with `rst` low.
- `op_we`  in  1  1 = store, 0 = load.
- `op_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `op_signed`  in  1  sign-extend a byte or half load.
- `op_addr`  in  12  byte address; any alignment is legal.
- `op_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  load result; 0 for stores and errors; held until the next `rsp_valid`.
- `rsp_err`  out  1  qualified by `rsp_valid`; illegal size.
- `mem_bus`  inout  32  shared data bus; driven only during store access cycles, Z otherwise.
- `mem_read`  out  1  memory drives the bus while high.
- `mem_write`  out  2  00 idle, 01 word write, 11 byte write (uses `mem_bus[7:0]`).
- `mem_addr`  out  12  access address.

## Operation
- States:
  - IDLE
  - ACC: an access is in flight; counter `cnt` runs 0..ACCESS_CYCLES-1.
  - GAP: bus released between the two halves of a halfword store.
  - RESP
- Accept in IDLE: register `op_*`.
  - Size 11 goes to RESP with `rsp_err=1`, `rsp_rdata=0`, and no bus activity.
  - Otherwise go to ACC with `cnt=0`.
- Load, any size: one ACC with `mem_read=1` and `mem_addr=op_addr`.
  - On `cnt==ACCESS_CYCLES-1`, capture `mem_bus`. The memory returns the 32 bits starting at the byte address.
  - Then go to RESP.
- Load alignment uses captured word `w`:
  - Byte: `w[7:0]`, sign- or zero-extended per `op_signed`.
  - Half: `w[15:0]`, extended the same way.
  - Word: `w`.
- Word store: one ACC with `mem_write=01` and `mem_bus=op_wdata`.
- Byte store: one ACC with `mem_write=11` and `mem_bus={24'b0,op_wdata[7:0]}`.
- Halfword store:
  - First ACC: byte write of `op_wdata[7:0]` at `op_addr`.
  - Then one GAP cycle.
  - Second ACC: byte write of `op_wdata[15:8]` at `op_addr+1`. The address is 12-bit modular, so 0xFFF wraps to 0x000.
- In GAP, IDLE and RESP: `mem_read=0`, `mem_write=00`, `mem_bus` Z, and `mem_addr` holds its last value.
- `mem_read` and a bus drive are never active in the same cycle. `mem_read` and a nonzero `mem_write` are never active together.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE.
- `req` is ignored when `ready=0`. No queueing.
- Reset, including mid-access, takes effect immediately:
  - State goes to IDLE and `cnt` to 0.
  - `mem_read=0`, `mem_write=00`, `mem_bus` Z, `mem_addr=0`.
  - `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `ready=0`.
  - An interrupted access is dropped with no response.

## Timing
- All outputs except `ready` and the bus enable are registered. `ready` is decoded from state. The bus enable comes from the registered state.
- Counting the accept edge as cycle 0, with ACCESS_CYCLES=N:
  - Load, word or byte store: ACC in cycles 1..N, `rsp_valid` in N+1, `ready` high in N+2.
  - Halfword store: ACC 1..N, GAP N+1, ACC N+2..2N+1, `rsp_valid` 2N+2.
  - Illegal size: `rsp_valid` in cycle 1.
- Control, address and write data are stable across all N cycles of an ACC.
- Back-to-back requests: minimum spacing between accepts is N+2 cycles. The RESP cycle doubles as the bus turnaround.

## Structure
- Package `lsu_pkg`:
  - `op_size` encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - `mem_write` encodings: MW_IDLE, MW_WORD, MW_BYTE.
  - State enum.
- Sub-module `lsu_load_align`: purely combinational. Inputs are the captured word, `op_size` and `op_signed`; output is `rsp_rdata`.
- The top module holds the FSM, counter and tri-state driver.

## Test plan
- Word load at 0x010; model returns 0xDEADBEEF → `mem_read` high for exactly 4 cycles, `rsp_rdata=0xDEADBEEF` at cycle 5, bus never driven by the DUT.
- Signed byte load returning 0x00000080 → `rsp_rdata=0xFFFFFF80`. Unsigned half load returning 0x1234F00D → `rsp_rdata=0x0000F00D`.
- Halfword store 0xABCD at 0xFFF:
  - Byte write 0xCD at 0xFFF.
  - One idle cycle with bus Z.
  - Byte write 0xAB at 0x000.
  - `rsp_valid` at cycle 10, `rsp_rdata=0`.
- `op_size=11` → `rsp_valid` and `rsp_err` at cycle 1, `mem_read`/`mem_write` never asserted.
- `req` held high continuously through two word stores → second accept exactly 6 cycles after the first; `req` during busy ignored.
- `rst` pulsed in cycle 2 of a word store → bus Z and `mem_write=00` within the same cycle, no `rsp_valid`, `ready=1` on the first cycle after `rst` falls.
